id_ex_stage: RTL and testbench

- ID/EX pipeline register of the RISC-V core. Sits directly upstream of the ALU and drives its in1, in2 and alu_control inputs.
- Decodes alu_op/funct3/funct7 into the team's 4-bit ALU control code and selects operand B (register or immediate).
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Supports stall (hold) and flush (bubble) from the hazard unit.

---
 rtl/id_ex_stage_if.sv | 65 ++++++
 rtl/id_ex_stage.sv | 154 +++++++++++++++
 tb/tb_id_ex_stage.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_if
// Description : Bundle between the decode side, the forwarding sources and
//               the ID/EX register. The stage is the slave; the decode side
//               (and the hazard unit that drives stall/flush) is the master.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    // Decode-side instruction fields and hazard-unit controls
    logic              in_valid;
    logic              stall;
    logic              flush;
    logic [1:0]        alu_op;
    logic [2:0]        funct3;
    logic              funct7_5;
    logic              alu_src;
    logic              reg_write;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [REG_AW-1:0] rd_addr;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;

    // Forwarding sources from later stages
    logic [REG_AW-1:0] exmem_rd;
    logic              exmem_reg_write;
    logic [XLEN-1:0]   exmem_result;
    logic [REG_AW-1:0] memwb_rd;
    logic              memwb_reg_write;
    logic [XLEN-1:0]   memwb_result;

    // Registered EX-stage outputs
    logic              ex_valid;
    logic [XLEN-1:0]   alu_in1;
    logic [XLEN-1:0]   alu_in2;
    logic [3:0]        alu_control;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_reg_write;
    logic [XLEN-1:0]   ex_store_data;
    logic              illegal_op;

    modport master (
        output in_valid, stall, flush, alu_op, funct3, funct7_5, alu_src,
               reg_write, rs1_addr, rs2_addr, rd_addr, rs1_data, rs2_data,
               imm, exmem_rd, exmem_reg_write, exmem_result, memwb_rd,
               memwb_reg_write, memwb_result,
        input  ex_valid, alu_in1, alu_in2, alu_control, ex_rd, ex_reg_write,
               ex_store_data, illegal_op
    );

    modport slave (
        input  in_valid, stall, flush, alu_op, funct3, funct7_5, alu_src,
               reg_write, rs1_addr, rs2_addr, rd_addr, rs1_data, rs2_data,
               imm, exmem_rd, exmem_reg_write, exmem_result, memwb_rd,
               memwb_reg_write, memwb_result,
        output ex_valid, alu_in1, alu_in2, alu_control, ex_rd, ex_reg_write,
               ex_store_data, illegal_op
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register. Decodes alu_op/funct3/funct7_5 into
//               the 4-bit ALU control code, selects operand B, forwards from
//               EX/MEM and MEM/WB, and honours stall (hold) / flush (bubble).
//               Optional macro ID_EX_FWD_EN enables the forwarding muxes;
//               without it operands come straight from the register file.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    id_ex_stage_if.slave  bus
);

    localparam logic [3:0] c_ALU_AND = 4'b0000;
    localparam logic [3:0] c_ALU_OR  = 4'b0001;
    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_XOR = 4'b0011;
    localparam logic [3:0] c_ALU_SLL = 4'b0100;
    localparam logic [3:0] c_ALU_SRL = 4'b0101;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;
    localparam logic [3:0] c_ALU_SLT = 4'b0111;
    localparam logic [3:0] c_ALU_SRA = 4'b1000;

    localparam logic [1:0] c_OP_MEM    = 2'b00;
    localparam logic [1:0] c_OP_BRANCH = 2'b01;
    localparam logic [1:0] c_OP_RTYPE  = 2'b10;

    logic [3:0]        w_alu_control;
    logic              w_illegal;
    logic [XLEN-1:0]   w_fwd_rs1;
    logic [XLEN-1:0]   w_fwd_rs2;
    logic [XLEN-1:0]   w_op_b;

    logic              r_ex_valid;
    logic [XLEN-1:0]   r_alu_in1;
    logic [XLEN-1:0]   r_alu_in2;
    logic [3:0]        r_alu_control;
    logic [REG_AW-1:0] r_ex_rd;
    logic              r_ex_reg_write;
    logic [XLEN-1:0]   r_ex_store_data;
    logic              r_illegal_op;

    // ALU control decode; unsupported encodings fall back to ADD and flag illegal
    always_comb begin
        w_alu_control = c_ALU_ADD;
        w_illegal     = 1'b0;
        if (bus.alu_op == c_OP_MEM) begin
            w_alu_control = c_ALU_ADD;
        end else if (bus.alu_op == c_OP_BRANCH) begin
            w_alu_control = c_ALU_SUB;
        end else begin
            // R-type and I-type share the funct3 table; only R-type honours
            // funct7_5 on funct3=000, and only R-type rejects stray funct7_5.
            case (bus.funct3)
                3'b000: w_alu_control = (bus.alu_op == c_OP_RTYPE && bus.funct7_5)
                                        ? c_ALU_SUB : c_ALU_ADD;
                3'b001: w_alu_control = c_ALU_SLL;
                3'b010: w_alu_control = c_ALU_SLT;
                3'b011: w_illegal     = 1'b1;
                3'b100: w_alu_control = c_ALU_XOR;
                3'b101: w_alu_control = bus.funct7_5 ? c_ALU_SRA : c_ALU_SRL;
                3'b110: w_alu_control = c_ALU_OR;
                default: w_alu_control = c_ALU_AND;
            endcase
            if (bus.alu_op == c_OP_RTYPE && bus.funct7_5 &&
                bus.funct3 != 3'b000 && bus.funct3 != 3'b101) begin
                w_illegal = 1'b1;
            end
            if (w_illegal) begin
                w_alu_control = c_ALU_ADD;
            end
        end
    end

`ifdef ID_EX_FWD_EN
    // Operand forwarding; EX/MEM is the younger result so it wins, x0 never forwards
    always_comb begin
        w_fwd_rs1 = bus.rs1_data;
        w_fwd_rs2 = bus.rs2_data;
        if (bus.exmem_reg_write && bus.exmem_rd == bus.rs1_addr && bus.rs1_addr != '0) begin
            w_fwd_rs1 = bus.exmem_result;
        end else if (bus.memwb_reg_write && bus.memwb_rd == bus.rs1_addr && bus.rs1_addr != '0) begin
            w_fwd_rs1 = bus.memwb_result;
        end
        if (bus.exmem_reg_write && bus.exmem_rd == bus.rs2_addr && bus.rs2_addr != '0) begin
            w_fwd_rs2 = bus.exmem_result;
        end else if (bus.memwb_reg_write && bus.memwb_rd == bus.rs2_addr && bus.rs2_addr != '0) begin
            w_fwd_rs2 = bus.memwb_result;
        end
    end
`else
    // No forwarding: the hazard unit stalls instead, so later-stage inputs are don't-care
    logic w_unused_fwd;
    assign w_unused_fwd = ^{bus.exmem_rd, bus.exmem_reg_write, bus.exmem_result,
                            bus.memwb_rd, bus.memwb_reg_write, bus.memwb_result};

    // Register-file data passes straight through to the operand muxes
    always_comb begin
        w_fwd_rs1 = bus.rs1_data;
        w_fwd_rs2 = bus.rs2_data;
    end
`endif

    assign w_op_b = bus.alu_src ? bus.imm : w_fwd_rs2;

    // Pipeline register: flush beats stall, stall holds, otherwise load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid      <= 1'b0;
            r_alu_in1       <= '0;
            r_alu_in2       <= '0;
            r_alu_control   <= c_ALU_AND;
            r_ex_rd         <= '0;
            r_ex_reg_write  <= 1'b0;
            r_ex_store_data <= '0;
            r_illegal_op    <= 1'b0;
        end else if (bus.flush) begin
            r_ex_valid      <= 1'b0;
            r_alu_in1       <= '0;
            r_alu_in2       <= '0;
            r_alu_control   <= c_ALU_AND;
            r_ex_rd         <= '0;
            r_ex_reg_write  <= 1'b0;
            r_ex_store_data <= '0;
            r_illegal_op    <= 1'b0;
        end else if (!bus.stall) begin
            r_ex_valid      <= bus.in_valid;
            r_alu_in1       <= w_fwd_rs1;
            r_alu_in2       <= w_op_b;
            r_alu_control   <= w_alu_control;
            r_ex_rd         <= bus.rd_addr;
            r_ex_reg_write  <= bus.in_valid && bus.reg_write && !w_illegal;
            r_ex_store_data <= w_fwd_rs2;
            r_illegal_op    <= bus.in_valid && w_illegal;
        end
    end

    assign bus.ex_valid      = r_ex_valid;
    assign bus.alu_in1       = r_alu_in1;
    assign bus.alu_in2       = r_alu_in2;
    assign bus.alu_control   = r_alu_control;
    assign bus.ex_rd         = r_ex_rd;
    assign bus.ex_reg_write  = r_ex_reg_write;
    assign bus.ex_store_data = r_ex_store_data;
    assign bus.illegal_op    = r_illegal_op;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Directed self-checking bench for id_ex_stage. Expectations
//               depend on whether ID_EX_FWD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    id_ex_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

    id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed: valid, ctrl, rd, rw, illegal, in1, in2, store
    function automatic logic [107:0] obs();
        return {bus.ex_valid, bus.alu_control, bus.ex_rd, bus.ex_reg_write,
                bus.illegal_op, bus.alu_in1, bus.alu_in2, bus.ex_store_data};
    endfunction

    function automatic logic [107:0] pk(input logic v, input logic [3:0] c,
                                        input logic [4:0] rd, input logic rw,
                                        input logic il, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] s);
        return {v, c, rd, rw, il, a, b, s};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] f3,
                         input logic f7, input logic src, input logic rw,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] im);
        bus.in_valid = v;  bus.alu_op = op;   bus.funct3 = f3;  bus.funct7_5 = f7;
        bus.alu_src = src; bus.reg_write = rw;
        bus.rs1_addr = r1; bus.rs2_addr = r2; bus.rd_addr = rd;
        bus.rs1_data = d1; bus.rs2_data = d2; bus.imm = im;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                           input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
        bus.exmem_reg_write = ew; bus.exmem_rd = erd; bus.exmem_result = eres;
        bus.memwb_reg_write = mw; bus.memwb_rd = mrd; bus.memwb_result = mres;
    endtask

    task automatic test_reset();
        logic [107:0] e;
        #2;
        checks++;
        if (obs() !== '0) begin failures++; $display("FAIL reset_initial got=%h exp=0", obs()); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs() !== '0) begin failures++; $display("FAIL reset_release got=%h exp=0", obs()); end
        // Load something nonzero, then assert reset mid-cycle
        drive(1, 2'b10, 3'b000, 1, 0, 1, 5'd1, 5'd2, 5'd7, 32'd10, 32'd3, 32'd0);
        step();
        e = pk(1, 4'b0110, 5'd7, 1, 0, 32'd10, 32'd3, 32'd3);
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL reset_preload got=%h exp=%h", obs(), e); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== '0) begin failures++; $display("FAIL reset_async got=%h exp=0", obs()); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs() !== '0) begin failures++; $display("FAIL reset_no_edge got=%h exp=0", obs()); end
    endtask

    task automatic test_rtype_sub();
        logic [107:0] e;
        drive(1, 2'b10, 3'b000, 1, 0, 1, 5'd1, 5'd2, 5'd7, 32'd10, 32'd3, 32'd0);
        step();
        e = pk(1, 4'b0110, 5'd7, 1, 0, 32'd10, 32'd3, 32'd3);
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL rtype_sub got=%h exp=%h", obs(), e); end
    endtask

    task automatic test_itype_sra();
        logic [107:0] e;
        drive(1, 2'b11, 3'b101, 1, 1, 1, 5'd3, 5'd4, 5'd9, 32'h8000_0000, 32'd99, 32'd2);
        step();
        e = pk(1, 4'b1000, 5'd9, 1, 0, 32'h8000_0000, 32'd2, 32'd99);
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL itype_sra got=%h exp=%h", obs(), e); end
        drive(1, 2'b11, 3'b000, 1, 1, 1, 5'd3, 5'd4, 5'd9, 32'h8000_0000, 32'd99, 32'd2);
        step();
        e = pk(1, 4'b0010, 5'd9, 1, 0, 32'h8000_0000, 32'd2, 32'd99);
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL itype_addi_f7 got=%h exp=%h", obs(), e); end
    endtask

    task automatic test_decode_table();
        logic [1:0] ops [10] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11};
        logic [2:0] f3s [10] = '{3'b111, 3'b111, 3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111, 3'b001};
        logic       f7s [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [3:0] exp [10] = '{4'b0010, 4'b0110, 4'b0010, 4'b0100, 4'b0111, 4'b0011,
                                 4'b0101, 4'b0001, 4'b0000, 4'b0100};
        for (int i = 0; i < 10; i++) begin
            drive(1, ops[i], f3s[i], f7s[i], 0, 1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd6, 32'd0);
            step();
            checks++;
            if (bus.alu_control !== exp[i] || bus.illegal_op !== 1'b0) begin
                failures++;
                $display("FAIL decode_%0d got ctrl=%b ill=%b exp ctrl=%b ill=0",
                         i, bus.alu_control, bus.illegal_op, exp[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [107:0] e;
        drive(1, 2'b10, 3'b011, 0, 0, 1, 5'd1, 5'd2, 5'd4, 32'd7, 32'd8, 32'd0);
        step();
        e = pk(1, 4'b0010, 5'd4, 0, 1, 32'd7, 32'd8, 32'd8);
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL illegal_sltu_r got=%h exp=%h", obs(), e); end
        drive(1, 2'b10, 3'b001, 1, 0, 1, 5'd1, 5'd2, 5'd4, 32'd7, 32'd8, 32'd0);
        step();
        e = pk(1, 4'b0010, 5'd4, 0, 1, 32'd7, 32'd8, 32'd8);
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL illegal_r_f7 got=%h exp=%h", obs(), e); end
        drive(1, 2'b11, 3'b011, 0, 1, 1, 5'd1, 5'd2, 5'd4, 32'd7, 32'd8, 32'd12);
        step();
        e = pk(1, 4'b0010, 5'd4, 0, 1, 32'd7, 32'd12, 32'd8);
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL illegal_sltiu got=%h exp=%h", obs(), e); end
        // A bubble carrying an illegal encoding reports nothing
        drive(0, 2'b10, 3'b011, 0, 0, 1, 5'd1, 5'd2, 5'd4, 32'd7, 32'd8, 32'd0);
        step();
        e = pk(0, 4'b0010, 5'd4, 0, 0, 32'd7, 32'd8, 32'd8);
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL bubble_illegal got=%h exp=%h", obs(), e); end
    endtask

    task automatic test_forwarding();
        logic [31:0] a, b, s;
        // Both sources match: EX/MEM wins
        drive(1, 2'b10, 3'b000, 0, 0, 1, 5'd5, 5'd5, 5'd6, 32'h11, 32'h22, 32'h44);
        set_fwd(1, 5'd5, 32'hAA, 1, 5'd5, 32'hBB);
        step();
`ifdef ID_EX_FWD_EN
        a = 32'hAA; b = 32'hAA; s = 32'hAA;
`else
        a = 32'h11; b = 32'h22; s = 32'h22;
`endif
        checks++;
        if (bus.alu_in1 !== a || bus.alu_in2 !== b || bus.ex_store_data !== s) begin
            failures++;
            $display("FAIL fwd_priority got=%h/%h/%h exp=%h/%h/%h",
                     bus.alu_in1, bus.alu_in2, bus.ex_store_data, a, b, s);
        end
        // Only MEM/WB matches
        set_fwd(0, 5'd5, 32'hAA, 1, 5'd5, 32'hBB);
        step();
`ifdef ID_EX_FWD_EN
        a = 32'hBB; b = 32'hBB; s = 32'hBB;
`endif
        checks++;
        if (bus.alu_in1 !== a || bus.alu_in2 !== b || bus.ex_store_data !== s) begin
            failures++;
            $display("FAIL fwd_memwb got=%h/%h/%h exp=%h/%h/%h",
                     bus.alu_in1, bus.alu_in2, bus.ex_store_data, a, b, s);
        end
        // Immediate operand B, rs2 still forwarded to store data
        drive(1, 2'b00, 3'b010, 0, 1, 0, 5'd5, 5'd5, 5'd6, 32'h11, 32'h22, 32'h44);
        set_fwd(1, 5'd5, 32'hAA, 0, 5'd0, 32'h0);
        step();
`ifdef ID_EX_FWD_EN
        a = 32'hAA; b = 32'h44; s = 32'hAA;
`else
        a = 32'h11; b = 32'h44; s = 32'h22;
`endif
        checks++;
        if (bus.alu_in1 !== a || bus.alu_in2 !== b || bus.ex_store_data !== s) begin
            failures++;
            $display("FAIL fwd_imm got=%h/%h/%h exp=%h/%h/%h",
                     bus.alu_in1, bus.alu_in2, bus.ex_store_data, a, b, s);
        end
        // x0 is never forwarded
        drive(1, 2'b10, 3'b000, 0, 0, 1, 5'd0, 5'd0, 5'd6, 32'h11, 32'h22, 32'h44);
        set_fwd(1, 5'd0, 32'hAA, 1, 5'd0, 32'hBB);
        step();
        checks++;
        if (bus.alu_in1 !== 32'h11 || bus.alu_in2 !== 32'h22 || bus.ex_store_data !== 32'h22) begin
            failures++;
            $display("FAIL fwd_x0 got=%h/%h/%h exp=11/22/22",
                     bus.alu_in1, bus.alu_in2, bus.ex_store_data);
        end
        // Matching rd without reg_write, non-matching writer: no forward
        drive(1, 2'b10, 3'b000, 0, 0, 1, 5'd5, 5'd5, 5'd6, 32'h11, 32'h22, 32'h44);
        set_fwd(0, 5'd5, 32'hAA, 1, 5'd6, 32'hBB);
        step();
        checks++;
        if (bus.alu_in1 !== 32'h11 || bus.alu_in2 !== 32'h22) begin
            failures++;
            $display("FAIL fwd_none got=%h/%h exp=11/22", bus.alu_in1, bus.alu_in2);
        end
        set_fwd(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    endtask

    task automatic test_stall_flush();
        logic [107:0] e;
        drive(1, 2'b10, 3'b000, 1, 0, 1, 5'd1, 5'd2, 5'd7, 32'd10, 32'd3, 32'd0);
        step();
        e = pk(1, 4'b0110, 5'd7, 1, 0, 32'd10, 32'd3, 32'd3);
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL stall_preload got=%h exp=%h", obs(), e); end
        // Hold for two cycles while every input, including forwarding, changes
        bus.stall = 1'b1;
        drive(1, 2'b11, 3'b100, 0, 1, 0, 5'd1, 5'd2, 5'd8, 32'd55, 32'd66, 32'd77);
        set_fwd(1, 5'd1, 32'hCC, 1, 5'd2, 32'hDD);
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (obs() !== e) begin failures++; $display("FAIL stall_hold_%0d got=%h exp=%h", i, obs(), e); end
            bus.memwb_result = 32'hEE;
        end
        // Flush overrides stall
        bus.flush = 1'b1;
        step();
        checks++;
        if (obs() !== '0) begin failures++; $display("FAIL flush_over_stall got=%h exp=0", obs()); end
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        set_fwd(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        step();
        e = pk(1, 4'b0011, 5'd8, 0, 0, 32'd55, 32'd77, 32'd66);
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL after_flush_load got=%h exp=%h", obs(), e); end
        bus.flush = 1'b1;
        step();
        checks++;
        if (obs() !== '0) begin failures++; $display("FAIL flush_only got=%h exp=0", obs()); end
        bus.flush = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        logic [107:0] e;
        drive(1, 2'b10, 3'b110, 0, 0, 1, 5'd1, 5'd2, 5'd3, 32'hF0, 32'h0F, 32'd0);
        step();
        bus.stall = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== '0) begin failures++; $display("FAIL reset_mid_stall got=%h exp=0", obs()); end
        rst_n = 1'b1;
        bus.stall = 1'b0;
        drive(1, 2'b11, 3'b111, 0, 1, 1, 5'd1, 5'd2, 5'd12, 32'hF0, 32'h0F, 32'h3C);
        step();
        e = pk(1, 4'b0000, 5'd12, 1, 0, 32'hF0, 32'h3C, 32'h0F);
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL post_reset_load got=%h exp=%h", obs(), e); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(0, 2'b00, 3'b000, 0, 0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        set_fwd(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        test_reset();
        test_rtype_sub();
        test_itype_sra();
        test_decode_table();
        test_illegal();
        test_forwarding();
        test_stall_flush();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
